acc_shift_unit: RTL and testbench
=================================

// Module: acc_shift_unit
// PURPOSE
//  Parametrised SAP-1 accumulator with an operate path: load from W-bus, single-cycle INC/DEC/CLR,
//  and multi-cycle shift/rotate by a programmable amount (one bit per clock) with start/done handshake.
//  Drives the ALU input unconditionally and the W-bus via tri-state under ea; exports Z/N/C flags.
// PARAMETERS
//  WIDTH    8                   accumulator / bus width in bits (>=2)
//  SHAMT_W  $clog2(WIDTH)+1     localparam; width of shift-amount port and internal counter
// PORTS
//  clk      in   1        rising-edge clock
//  clr_n    in   1        asynchronous active-low reset
//  data_in  in   WIDTH    W-bus data for load
//  la       in   1        load A, active-low (la==0 loads data_in)
//  ea       in   1        bus enable, active-high; drives to_bus
//  start    in   1        launch op (sampled only in IDLE)
//  op       in   3        operation code, sampled with start
//  shamt    in   SHAMT_W  shift count for shift/rotate ops, sampled with start
//  busy     out  1        high in SHIFT and DONE states
//  done     out  1        one-cycle pulse at completion of every started op
//  to_alu   out  WIDTH    A, always driven
//  to_bus   out  WIDTH    ea ? A : all 'z
//  zero     out  1        A == 0 (combinational)
//  neg      out  1        A[WIDTH-1] (combinational)
//  cout     out  1        carry/borrow/last-bit-out register
// BEHAVIOUR
//  Reset (clr_n=0, async): A=0, cout=0, state=IDLE, cnt=0; hence busy=0, done=0, zero=1, neg=0.
//  FSM states IDLE, SHIFT, DONE:
//   IDLE: la==0 -> A<=data_in, cout<=0, stay IDLE (load beats start when both asserted; start dropped).
//         else start -> execute op:
//          0 INC: A<=A+1, cout<=carry (1 iff A was all ones, A wraps to 0) -> DONE
//          1 DEC: A<=A-1, cout<=borrow (1 iff A was 0, A wraps to all ones) -> DONE
//          2 SHL  3 SHR(logical)  4 ASR  5 ROL  6 ROR: cnt<=shamt;
//            shamt==0 -> DONE with A and cout unchanged; else -> SHIFT
//          7 CLR: A<=0, cout<=0 -> DONE
//   SHIFT: each cycle one-bit step of latched op on A; cout<=bit shifted/rotated out; cnt<=cnt-1;
//          cnt==1 on this step -> DONE. Total: shamt cycles in SHIFT.
//   DONE:  done=1 for exactly this cycle -> IDLE.
//  Latency: INC/DEC/CLR/shamt=0 -> done 1 cycle after start edge; shift by k -> done k+1 cycles after.
//  la, start, op, shamt ignored while busy (op and shamt latched at start). shamt > WIDTH allowed:
//   SHL/SHR give 0, ASR gives sign fill, ROL/ROR wrap modulo WIDTH naturally.
//  to_bus honours ea in every state (intermediate shift values visible); to_alu/flags track A each cycle.
//  Reset asserted mid-shift aborts immediately; no done pulse is produced.
// STRUCTURE
//  sap1_pkg: localparams OP_INC..OP_CLR (3-bit encodings above), FSM state encodings.
//  Sub-module acc_shift_step (combinational): {a, op} -> {a_next, bit_out} for one-bit shift/rotate.
//  Top holds A, cout, cnt, op latch, FSM, and the tri-state driver.
// TESTING (WIDTH=8)
//  Reset then la=0, data_in=0x3C -> A=0x3C, zero=0, cout=0; ea=0 -> to_bus=Z; ea=1 -> to_bus=0x3C.
//  A=0xFF, start op=INC -> A=0x00, cout=1, zero=1, done pulses next cycle; then DEC -> A=0xFF, cout=1.
//  A=0x81, ROR shamt=3 -> busy 4 cycles, A sequence 0xC0,0x60,0x30, cout=0 at end, done one cycle.
//  A=0x80, ASR shamt=9 -> A=0xFF, neg=1; A=0x96 SHL shamt=0 -> done next cycle, A=0x96 unchanged.
//  A=0x10, start op=SHL with la=0, data_in=0x55 same cycle -> A=0x55, no done; la=0 during SHIFT ignored.
//  clr_n pulsed low mid-shift (asynchronous to clk) -> A=0, busy=0, done never asserted.

Source files
------------

// File: rtl/sap1_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sap1_pkg
// Description : Shared operation codes and FSM state encodings for the SAP-1
//               accumulator/shift unit.
// Revision    : 1.0  initial release
// ============================================================================
package sap1_pkg;

    // Operation codes, sampled together with start
    localparam logic [2:0] OP_INC = 3'd0;
    localparam logic [2:0] OP_DEC = 3'd1;
    localparam logic [2:0] OP_SHL = 3'd2;
    localparam logic [2:0] OP_SHR = 3'd3;
    localparam logic [2:0] OP_ASR = 3'd4;
    localparam logic [2:0] OP_ROL = 3'd5;
    localparam logic [2:0] OP_ROR = 3'd6;
    localparam logic [2:0] OP_CLR = 3'd7;

    // Control FSM state encodings
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

endpackage
`default_nettype wire

// File: rtl/acc_shift_step.sv
`default_nettype none
// ============================================================================
// Module      : acc_shift_step
// Description : Combinational one-bit shift/rotate step. Returns the next
//               accumulator value and the bit that leaves the word.
// Revision    : 1.0  initial release
// ============================================================================
module acc_shift_step
    import sap1_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [2:0]       op_i,
    output logic [WIDTH-1:0] a_next_o,
    output logic             bit_out_o
);

    // One step of the selected shift/rotate; non-shift codes pass A through
    always_comb begin
        a_next_o  = a_i;
        bit_out_o = 1'b0;
        case (op_i)
            OP_SHL: begin
                a_next_o  = {a_i[WIDTH-2:0], 1'b0};
                bit_out_o = a_i[WIDTH-1];
            end
            OP_SHR: begin
                a_next_o  = {1'b0, a_i[WIDTH-1:1]};
                bit_out_o = a_i[0];
            end
            OP_ASR: begin
                a_next_o  = {a_i[WIDTH-1], a_i[WIDTH-1:1]};
                bit_out_o = a_i[0];
            end
            OP_ROL: begin
                a_next_o  = {a_i[WIDTH-2:0], a_i[WIDTH-1]};
                bit_out_o = a_i[WIDTH-1];
            end
            OP_ROR: begin
                a_next_o  = {a_i[0], a_i[WIDTH-1:1]};
                bit_out_o = a_i[0];
            end
            default: begin
                a_next_o  = a_i;
                bit_out_o = 1'b0;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/acc_shift_unit.sv
`default_nettype none
// ============================================================================
// Module      : acc_shift_unit
// Description : SAP-1 accumulator with load, INC/DEC/CLR and multi-cycle
//               shift/rotate (one bit per clock) behind a start/done
//               handshake. Drives the ALU input and a tri-stated W-bus.
// Revision    : 1.0  initial release
// ============================================================================
module acc_shift_unit
    import sap1_pkg::*;
#(
    parameter  int WIDTH   = 8,
    localparam int SHAMT_W = $clog2(WIDTH) + 1
) (
    input  logic               clk,
    input  logic               clr_n,
    input  logic [WIDTH-1:0]   data_in,
    input  logic               la,
    input  logic               ea,
    input  logic               start,
    input  logic [2:0]         op,
    input  logic [SHAMT_W-1:0] shamt,
    output logic               busy,
    output logic               done,
    output logic [WIDTH-1:0]   to_alu,
    output wire  [WIDTH-1:0]   to_bus,
    output logic               zero,
    output logic               neg,
    output logic               cout
);

    localparam logic [WIDTH-1:0]   A_ONE   = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [SHAMT_W-1:0] CNT_ONE = {{(SHAMT_W-1){1'b0}}, 1'b1};
    localparam logic [SHAMT_W-1:0] CNT_ZERO = '0;

    logic [1:0]         state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic               cout_q, cout_d;
    logic [SHAMT_W-1:0] cnt_q, cnt_d;
    logic [2:0]         op_q, op_d;

    logic [WIDTH-1:0]   step_a;
    logic               step_bit;

    // The step unit always works on the latched op so inputs may change mid-shift
    acc_shift_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .a_i       (a_q),
        .op_i      (op_q),
        .a_next_o  (step_a),
        .bit_out_o (step_bit)
    );

    // Next-state logic: load has priority over start in IDLE; inputs ignored while busy
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        cout_d  = cout_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        case (state_q)
            ST_IDLE: begin
                if (!la) begin
                    a_d    = data_in;
                    cout_d = 1'b0;
                end else if (start) begin
                    op_d    = op;
                    state_d = ST_DONE;
                    case (op)
                        OP_INC: begin
                            a_d    = a_q + A_ONE;
                            cout_d = &a_q;
                        end
                        OP_DEC: begin
                            a_d    = a_q - A_ONE;
                            cout_d = ~|a_q;
                        end
                        OP_CLR: begin
                            a_d    = '0;
                            cout_d = 1'b0;
                        end
                        default: begin
                            // Zero-length shifts finish immediately with A and cout intact
                            cnt_d = shamt;
                            if (shamt != CNT_ZERO) begin
                                state_d = ST_SHIFT;
                            end
                        end
                    endcase
                end
            end
            ST_SHIFT: begin
                a_d    = step_a;
                cout_d = step_bit;
                cnt_d  = cnt_q - CNT_ONE;
                if (cnt_q == CNT_ONE) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers with asynchronous active-low clear
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            cout_q  <= 1'b0;
            cnt_q   <= '0;
            op_q    <= OP_INC;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            cout_q  <= cout_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
        end
    end

    assign busy   = (state_q == ST_SHIFT) || (state_q == ST_DONE);
    assign done   = (state_q == ST_DONE);
    assign to_alu = a_q;
    assign zero   = (a_q == '0);
    assign neg    = a_q[WIDTH-1];
    assign cout   = cout_q;
    assign to_bus = ea ? a_q : {WIDTH{1'bz}};

endmodule
`default_nettype wire

// File: tb/tb_acc_shift_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_acc_shift_unit
// Description : Scoreboard bench for acc_shift_unit (WIDTH=8). Expected
//               results come from an arithmetic reference model; a monitor
//               pops and compares on every done pulse.
// Revision    : 1.0  initial release
// ============================================================================
module tb_acc_shift_unit;
    import sap1_pkg::*;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         clr_n = 1'b0;
    logic [W-1:0] data_in = '0;
    logic         la = 1'b1;
    logic         ea = 1'b0;
    logic         start = 1'b0;
    logic [2:0]   op = 3'd0;
    logic [3:0]   shamt = 4'd0;
    logic         busy, done, zero, neg, cout;
    logic [W-1:0] to_alu;
    wire  [W-1:0] to_bus;

    acc_shift_unit #(.WIDTH(W)) dut (
        .clk     (clk),
        .clr_n   (clr_n),
        .data_in (data_in),
        .la      (la),
        .ea      (ea),
        .start   (start),
        .op      (op),
        .shamt   (shamt),
        .busy    (busy),
        .done    (done),
        .to_alu  (to_alu),
        .to_bus  (to_bus),
        .zero    (zero),
        .neg     (neg),
        .cout    (cout)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        logic [W-1:0] a;
        logic         c;
        int           cyc;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    logic [W-1:0] model_a = '0;
    logic         model_c = 1'b0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, got, exp, $time);
    endtask

    // Reference model: whole-operation result computed directly from the shift amount
    function automatic void model(input logic [2:0] o, input logic [W-1:0] a, input logic cin,
                                  input int k, output logic [W-1:0] r, output logic c);
        logic [15:0]        v;
        logic signed [15:0] s;
        int                 m;
        r = a;
        c = cin;
        case (o)
            OP_INC: begin r = a + 8'd1; c = (a == 8'hFF); end
            OP_DEC: begin r = a - 8'd1; c = (a == 8'h00); end
            OP_CLR: begin r = '0; c = 1'b0; end
            default: begin
                if (k != 0) begin
                    m = k % W;
                    case (o)
                        OP_SHL: begin v = {8'h00, a} << k; r = v[7:0]; c = v[8]; end
                        OP_SHR: begin v = {a, 8'h00} >> k; r = v[15:8]; c = v[7]; end
                        OP_ASR: begin s = $signed({a, 8'h00}) >>> k; r = s[15:8]; c = s[7]; end
                        OP_ROL: begin v = {a, a} << m; r = v[15:8]; c = r[0]; end
                        default: begin v = {a, a} >> m; r = v[7:0]; c = r[W-1]; end
                    endcase
                end
            end
        endcase
    endfunction

    // Monitor: every done pulse must match the oldest outstanding expectation
    always @(negedge clk) begin
        exp_t e;
        if (clr_n && done) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", 32'(done), 32'd0);
            end else begin
                e = sb.pop_front();
                chk("sb_a", 32'(to_alu), 32'(e.a));
                chk("sb_cout", 32'(cout), 32'(e.c));
                chk("sb_zero", 32'(zero), 32'(e.a == 0));
                chk("sb_neg", 32'(neg), 32'(e.a[W-1]));
                chk("sb_latency", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    // Load A from the W-bus (called on a negedge, returns on a negedge)
    task automatic load(input logic [W-1:0] d);
        la = 1'b0;
        data_in = d;
        @(negedge clk);
        la = 1'b1;
        model_a = d;
        model_c = 1'b0;
    endtask

    // Launch an op and queue its expected outcome
    task automatic issue(input logic [2:0] o, input int k);
        logic [W-1:0] r;
        logic         c;
        int           lat;
        model(o, model_a, model_c, k, r, c);
        lat = ((o inside {OP_SHL, OP_SHR, OP_ASR, OP_ROL, OP_ROR}) && k != 0) ? k + 1 : 1;
        sb.push_back('{a: r, c: c, cyc: cyc + lat});
        model_a = r;
        model_c = c;
        start = 1'b1;
        op    = o;
        shamt = 4'(k);
        @(negedge clk);
        start = 1'b0;
        op    = 3'($urandom_range(0, 7));
        shamt = 4'($urandom_range(0, 15));
    endtask

    // Wait for the unit to return to idle, optionally wiggling la/data_in meanwhile
    task automatic wait_idle(input bit noise);
        int n = 0;
        while (busy && n < 40) begin
            if (noise && !done) begin
                la = 1'($urandom_range(0, 1));
                data_in = 8'($urandom);
            end else begin
                la = 1'b1;
            end
            @(negedge clk);
            n++;
        end
        la = 1'b1;
        if (n >= 40) chk("idle_timeout", 32'(busy), 32'd0);
        else chk("done_one_cycle", 32'(done), 32'd0);
    endtask

    initial begin
        // Reset state
        #12;
        chk("rst_a", 32'(to_alu), 32'h0);
        chk("rst_cout", 32'(cout), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_done", 32'(done), 32'h0);
        chk("rst_zero", 32'(zero), 32'h1);
        chk("rst_neg", 32'(neg), 32'h0);
        @(negedge clk);
        clr_n = 1'b1;
        @(negedge clk);

        // Load and bus enable
        load(8'h3C);
        chk("load_a", 32'(to_alu), 32'h3C);
        chk("load_zero", 32'(zero), 32'h0);
        chk("load_cout", 32'(cout), 32'h0);
        ea = 1'b0;
        #1;
        n_checks++;
        if (to_bus !== 8'h3C) n_pass++;
        else $display("FAIL bus_released: got 0x%0h expected not driven", to_bus);
        ea = 1'b1;
        #1;
        chk("bus_driven", 32'(to_bus), 32'h3C);
        ea = 1'b0;
        @(negedge clk);

        // INC wrap then DEC wrap
        load(8'hFF);
        issue(OP_INC, 0);
        wait_idle(0);
        issue(OP_DEC, 0);
        wait_idle(0);

        // ROR 0x81 by 3 with per-cycle A sequence
        load(8'h81);
        issue(OP_ROR, 3);
        chk("ror_busy0", 32'(busy), 32'h1);
        chk("ror_a0", 32'(to_alu), 32'h81);
        @(negedge clk);
        chk("ror_a1", 32'(to_alu), 32'hC0);
        @(negedge clk);
        chk("ror_a2", 32'(to_alu), 32'h60);
        @(negedge clk);
        chk("ror_a3", 32'(to_alu), 32'h30);
        chk("ror_busy3", 32'(busy), 32'h1);
        @(negedge clk);
        chk("ror_idle", 32'(busy), 32'h0);

        // ASR beyond width, zero-length shift
        load(8'h80);
        issue(OP_ASR, 9);
        wait_idle(1);
        load(8'h96);
        issue(OP_SHL, 0);
        wait_idle(0);

        // Load beats start in the same cycle
        load(8'h10);
        la = 1'b0;
        data_in = 8'h55;
        start = 1'b1;
        op = OP_SHL;
        shamt = 4'd3;
        @(negedge clk);
        la = 1'b1;
        start = 1'b0;
        model_a = 8'h55;
        model_c = 1'b0;
        chk("ldstart_a", 32'(to_alu), 32'h55);
        chk("ldstart_busy", 32'(busy), 32'h0);
        repeat (4) @(negedge clk);
        chk("ldstart_a_later", 32'(to_alu), 32'h55);

        // Randomized operations
        for (int i = 0; i < 80; i++) begin
            if ($urandom_range(0, 3) == 0) load(8'($urandom));
            ea = 1'($urandom_range(0, 1));
            issue(3'($urandom_range(0, 7)), int'($urandom_range(0, 15)));
            if (ea) chk("rand_bus", 32'(to_bus), 32'(to_alu));
            wait_idle(1);
        end

        // Asynchronous reset in the middle of a shift
        load(8'hA5);
        issue(OP_SHL, 10);
        @(negedge clk);
        #3;
        clr_n = 1'b0;
        #1;
        chk("abort_a", 32'(to_alu), 32'h0);
        chk("abort_busy", 32'(busy), 32'h0);
        chk("abort_done", 32'(done), 32'h0);
        sb.delete();
        model_a = '0;
        model_c = 1'b0;
        #2;
        clr_n = 1'b1;
        repeat (14) @(negedge clk);
        chk("abort_still_idle", 32'(busy), 32'h0);
        chk("abort_a_hold", 32'(to_alu), 32'h0);

        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
